thread_scheduler: RTL
=====================

# thread_scheduler

Fine-grained multithreading issue scheduler for the 8-thread in-order core. Each cycle it picks the thread whose PC the IF stage fetches next, using round-robin over eligible threads. A thread is eligible when it is not stalled by a cache/TLB miss, has not reached its end PC, is not in a post-redirect hold window, and passes the exception fence. The block drives `scheduler_thread` for IF and for the top-level PC-speculation logic, and tracks the single-master exception state.

## Interface
- N_THREADS, 8: number of hardware threads; must be a power of two, at least 2.
- TID_W, $clog2(N_THREADS): thread-id width; matches `threadid_t`.
- HOLD, 2: extra cycles a thread stays ineligible after its PC is redirected at commit; at least 1.

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stalled  in  N_THREADS  per-thread miss stall from IF/TL; bit t=1 makes thread t ineligible
- done  in  N_THREADS  per-thread finished flag (waiting PC == end PC); sticky by contract
- redirect_en  in  1  commit stage redirected a thread's PC this cycle (jump, branch taken, retry, IRET, exception entry)
- redirect_thread  in  TID_W  thread redirected
- exc_en  in  1  exception entry pulse from commit
- exc_thread  in  TID_W  thread taking the exception
- iret_en  in  1  IRET committed by the exception master
- sched_valid  out  1  sched_thread is an eligible pick for this cycle
- sched_thread  out  TID_W  thread selected for fetch this cycle
- exc_active  out  1  exception state active; only the master may issue
- exc_master  out  TID_W  owner of the exception state
- all_done  out  1  every bit of done is set

## Operation
- State:
  - last: the previously granted thread id.
  - hold_cnt[t]: per-thread counter, width $clog2(HOLD+1).
  - exc_active and exc_master.
  - Registered outputs sched_valid and sched_thread.
- Eligibility, computed combinationally each cycle: elig[t] = ~stalled[t] & ~done[t] & (hold_cnt[t]==0) & ~(redirect_en & redirect_thread==t) & (~exc_active | t==exc_master).
- Selection:
  - Search starts at (last+1) mod N_THREADS and wraps.
  - The first thread with elig set is registered into sched_thread, sched_valid is set to 1, and last is updated.
  - If no thread is eligible: sched_valid=0, sched_thread and last hold their values.
- Hold counters:
  - redirect_en loads hold_cnt[redirect_thread] with HOLD, even if that counter is already nonzero.
  - Otherwise a nonzero counter decrements by 1 each cycle.
- Exception state machine has two states, IDLE and EXC.
  - IDLE to EXC on exc_en: exc_master is set to exc_thread.
  - EXC to IDLE on iret_en.
  - exc_en in EXC is ignored; the master is unchanged.
  - iret_en in IDLE is ignored.
  - exc_en and iret_en in the same cycle: in IDLE, exc_en wins and the state goes to EXC. In EXC, iret_en wins and the state goes to IDLE.
- The exception fence takes effect on the first selection computed after the exc_active edge. It does not affect the pick registered in the same cycle as exc_en.
- all_done is registered: &done delayed by one cycle.
- Reset values:
  - sched_valid=0, sched_thread=0, last=N_THREADS-1 (so the first grant is thread 0).
  - all hold_cnt=0, exc_active=0, exc_master=0, all_done=0.
  - rst mid-operation aborts any hold windows and exception state in the same edge.

## Timing
- Latency from any input to the outputs is 1 cycle: a selection computed in cycle k appears on sched_thread/sched_valid in cycle k+1.
- With all threads eligible, grants rotate 0,1,...,N-1,0 with one new thread every cycle and no bubbles.
- Redirect in cycle k:
  - The redirected thread is ineligible in the selections computed in cycles k through k+HOLD, which is HOLD+1 cycles.
  - Its earliest appearance on sched_thread is cycle k+HOLD+2.
- A stalled bit that drops in cycle k makes the thread grantable on sched_thread in cycle k+1.
- Thread-id arithmetic wraps modulo N_THREADS with no overflow handling needed, because N_THREADS is a power of two.
- No handshake with IF: IF consumes sched_thread every cycle that sched_valid=1. When sched_valid=0, IF inserts a bubble and does not fetch.

## Test plan
- Rotation: rst for 2 cycles, then all inputs 0 → sched_valid=1 from the first cycle after reset, sched_thread 0,1,...,7,0,... with no gaps.
- Skip: stalled=8'b0010_0100 → sched_thread sequence 0,1,3,4,6,7,0. Drop stalled[2] in the cycle that grants 3 → thread 2 is granted only after 7, since the pointer continues from last.
- Redirect hold: HOLD=2, only thread 5 not done, redirect_en with thread 5 at cycle 10 → sched_valid=0 in cycles 11-13; sched_thread=5 with sched_valid=1 at cycle 14.
- Exception fence:
  - exc_en with exc_thread=3 at cycle 20 → exc_active=1 and exc_master=3 at cycle 21; from cycle 22 only thread 3 is granted.
  - exc_en with thread 6 while in EXC → no change.
  - iret_en at cycle 40 → exc_active=0 at cycle 41; round-robin resumes at cycle 42 from last+1.
- Simultaneous exc_en and iret_en: in IDLE → enters EXC; in EXC → returns to IDLE.
- All blocked / done:
  - stalled=8'hFF → sched_valid=0 and sched_thread holds its last value.
  - done=8'hFF → all_done=1 one cycle later and sched_valid=0.
  - rst asserted mid-run with HOLD windows active → all outputs at reset values the next cycle; first grant after reset is thread 0.

Source files
------------

// File: rtl/thread_scheduler.sv
// Fine-grained multithreading issue scheduler: round-robin pick of the next
// fetch thread among eligible threads, with redirect hold windows and an exception fence.
module thread_scheduler #(
  parameter int N_THREADS = 8,
  parameter int TID_W     = $clog2(N_THREADS),
  parameter int HOLD      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_THREADS-1:0] stalled,
  input  logic [N_THREADS-1:0] done,
  input  logic                 redirect_en,
  input  logic [TID_W-1:0]     redirect_thread,
  input  logic                 exc_en,
  input  logic [TID_W-1:0]     exc_thread,
  input  logic                 iret_en,
  output logic                 sched_valid,
  output logic [TID_W-1:0]     sched_thread,
  output logic                 exc_active,
  output logic [TID_W-1:0]     exc_master,
  output logic                 all_done
);

  localparam int HCW = $clog2(HOLD + 1);

  typedef enum logic {
    IDLE = 1'b0,
    EXC  = 1'b1
  } exc_state_t;

  exc_state_t           exc_state;
  exc_state_t           exc_state_next;
  logic [TID_W-1:0]     last;
  logic [HCW-1:0]       hold_cnt [N_THREADS];
  logic [N_THREADS-1:0] elig;
  logic                 pick_valid;
  logic [TID_W-1:0]     pick_thread;
  logic [TID_W-1:0]     cand;

  // The fence reads the registered exception state, so the pick made in the
  // same cycle as exc_en is still unfenced.
  always_comb begin
    elig = '0;
    for (int t = 0; t < N_THREADS; t++) begin
      elig[t] = ~stalled[t] & ~done[t] & (hold_cnt[t] == '0)
              & ~(redirect_en && (redirect_thread == TID_W'(t)))
              & (~exc_active | (exc_master == TID_W'(t)));
    end
  end

  always_comb begin
    pick_valid  = 1'b0;
    pick_thread = last;
    cand        = '0;
    for (int i = 1; i <= N_THREADS; i++) begin
      cand = last + TID_W'(i);
      if (!pick_valid && elig[cand]) begin
        pick_valid  = 1'b1;
        pick_thread = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sched_valid  <= 1'b0;
      sched_thread <= '0;
      last         <= TID_W'(N_THREADS - 1);
    end else begin
      sched_valid <= pick_valid;
      if (pick_valid) begin
        sched_thread <= pick_thread;
        last         <= pick_thread;
      end
    end
  end

  // A repeated redirect reloads the full window even if one is already running.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < N_THREADS; t++) hold_cnt[t] <= '0;
    end else begin
      for (int t = 0; t < N_THREADS; t++) begin
        if (redirect_en && (redirect_thread == TID_W'(t))) begin
          hold_cnt[t] <= HCW'(HOLD);
        end else if (hold_cnt[t] != '0) begin
          hold_cnt[t] <= hold_cnt[t] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) exc_state <= IDLE;
    else     exc_state <= exc_state_next;
  end

  always_comb begin
    exc_state_next = exc_state;
    case (exc_state)
      IDLE:    if (exc_en)  exc_state_next = EXC;
      EXC:     if (iret_en) exc_state_next = IDLE;
      default: exc_state_next = IDLE;
    endcase
  end

  always_comb begin
    exc_active = (exc_state == EXC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exc_master <= '0;
      all_done   <= 1'b0;
    end else begin
      if ((exc_state == IDLE) && exc_en) exc_master <= exc_thread;
      all_done <= &done;
    end
  end

endmodule
